// File: rtl/mgmt_mdio_arbiter_pkg.sv
// Shared types and constants for the MDIO management arbiter.
package mgmt_mdio_arbiter_pkg;

    typedef struct packed {
        logic        write;
        logic [4:0]  md_addr;
        logic [4:0]  reg_addr;
        logic [15:0] wdata;
    } mdio_req_t;

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWaitRise,
        StWaitFall,
        StDone
    } mdio_arb_state_t;

    localparam logic [4:0]  MDIO_REG_BMSR      = 5'h01;
    localparam int unsigned MDIO_BMSR_LINK_BIT = 2;

endpackage

// File: rtl/mgmt_mdio_arbiter_rr_picker.sv
// Combinational round-robin priority encoder: first asserted request at or after ptr_i, wrapping.
module mgmt_mdio_arbiter_rr_picker #(
    parameter int unsigned N    = 3,
    parameter int unsigned IdxW = 2
) (
    input  logic [N-1:0]    req_i,
    input  logic [IdxW-1:0] ptr_i,
    output logic            valid_o,
    output logic [IdxW-1:0] idx_o
);

    always_comb begin
        int unsigned idx;
        idx     = 0;
        valid_o = 1'b0;
        idx_o   = '0;
        for (int unsigned off = 0; off < N; off++) begin
            idx = (32'(ptr_i) + off) % N;
            if (!valid_o && req_i[idx]) begin
                valid_o = 1'b1;
                idx_o   = IdxW'(idx);
            end
        end
    end

endmodule

// File: rtl/mgmt_mdio_arbiter.sv
// Round-robin arbiter sharing one MDIO transceiver between NUM_REQ requesters.
// Optional internal autopoll requester enabled by defining MDIO_AUTOPOLL_EN.
module mgmt_mdio_arbiter
    import mgmt_mdio_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ       = 2,
    parameter int unsigned BUSY_TIMEOUT  = 16,
    parameter int unsigned POLL_INTERVAL = 25000000,
    parameter logic [4:0]  POLL_PHY_ADDR = 5'h00
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ-1:0]    req_write,
    input  logic [5*NUM_REQ-1:0]  req_md_addr,
    input  logic [5*NUM_REQ-1:0]  req_reg_addr,
    input  logic [16*NUM_REQ-1:0] req_wdata,
    output logic [NUM_REQ-1:0]    done,
    output logic [NUM_REQ-1:0]    err,
    output logic [15:0]           rdata,
    output logic [4:0]            phy_md_addr,
    output logic [4:0]            phy_reg_addr,
    output logic [15:0]           phy_wr_data,
    output logic                  phy_reg_wr,
    output logic                  phy_reg_rd,
    input  logic [15:0]           phy_rd_data,
    input  logic                  mgmt_busy,
    output logic                  poll_link_up,
    output logic                  poll_valid
);

    localparam int unsigned NumSlots = NUM_REQ + 1;
    localparam int unsigned IdxW     = $clog2(NumSlots);
    localparam int unsigned ToW      = $clog2(BUSY_TIMEOUT + 1);

    if (NUM_REQ < 1 || NUM_REQ > 4) begin : g_bad_num_req
        $error("NUM_REQ must be 1..4");
    end
    if (BUSY_TIMEOUT < 1 || POLL_INTERVAL < 2) begin : g_bad_timing
        $error("BUSY_TIMEOUT must be >= 1 and POLL_INTERVAL >= 2");
    end

    mdio_arb_state_t state_q, state_d;
    logic [IdxW-1:0] grant_q, grant_d;
    logic [IdxW-1:0] rr_q, rr_d;
    logic [ToW-1:0]  to_cnt_q, to_cnt_d;
    logic            err_q, err_d;
    logic            write_q, write_d;
    logic [15:0]     rdata_q, rdata_d;
    logic [4:0]      phy_md_addr_q, phy_md_addr_d;
    logic [4:0]      phy_reg_addr_q, phy_reg_addr_d;
    logic [15:0]     phy_wr_data_q, phy_wr_data_d;
    logic            rd_stb_q, rd_stb_d;
    logic            wr_stb_q, wr_stb_d;

    mdio_req_t             slot_req [NumSlots];
    logic [NumSlots-1:0]   slot_valid;
    logic                  poll_req;
    logic                  pick_valid;
    logic [IdxW-1:0]       pick_idx;

    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            slot_req[i].write    = req_write[i];
            slot_req[i].md_addr  = req_md_addr[5*i +: 5];
            slot_req[i].reg_addr = req_reg_addr[5*i +: 5];
            slot_req[i].wdata    = req_wdata[16*i +: 16];
        end
        slot_req[NUM_REQ] = '{write: 1'b0, md_addr: POLL_PHY_ADDR,
                              reg_addr: MDIO_REG_BMSR, wdata: 16'h0000};
    end

    // Autopoll only competes when no external requester is asking.
    assign slot_valid = {poll_req & ~(|req_valid), req_valid};

    mgmt_mdio_arbiter_rr_picker #(
        .N    (NumSlots),
        .IdxW (IdxW)
    ) u_picker (
        .req_i   (slot_valid),
        .ptr_i   (rr_q),
        .valid_o (pick_valid),
        .idx_o   (pick_idx)
    );

    always_comb begin
        state_d        = state_q;
        grant_d        = grant_q;
        rr_d           = rr_q;
        to_cnt_d       = to_cnt_q;
        err_d          = err_q;
        write_d        = write_q;
        rdata_d        = rdata_q;
        phy_md_addr_d  = phy_md_addr_q;
        phy_reg_addr_d = phy_reg_addr_q;
        phy_wr_data_d  = phy_wr_data_q;
        rd_stb_d       = 1'b0;
        wr_stb_d       = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (pick_valid && !mgmt_busy) begin
                    state_d        = StIssue;
                    grant_d        = pick_idx;
                    err_d          = 1'b0;
                    write_d        = slot_req[pick_idx].write;
                    phy_md_addr_d  = slot_req[pick_idx].md_addr;
                    phy_reg_addr_d = slot_req[pick_idx].reg_addr;
                    phy_wr_data_d  = slot_req[pick_idx].wdata;
                    wr_stb_d       = slot_req[pick_idx].write;
                    rd_stb_d       = ~slot_req[pick_idx].write;
                    if (32'(pick_idx) < NUM_REQ) begin
                        rr_d = IdxW'((32'(pick_idx) + 1) % NUM_REQ);
                    end
                end
            end
            StIssue: begin
                to_cnt_d = '0;
                state_d  = StWaitRise;
            end
            StWaitRise: begin
                // Timeout lands DONE exactly BUSY_TIMEOUT cycles after entering this state.
                if (mgmt_busy) begin
                    state_d = StWaitFall;
                end else if (to_cnt_q == ToW'(BUSY_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = StDone;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            StWaitFall: begin
                if (!mgmt_busy) begin
                    if (!write_q) begin
                        rdata_d = phy_rd_data;
                    end
                    state_d = StDone;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            grant_q        <= '0;
            rr_q           <= '0;
            to_cnt_q       <= '0;
            err_q          <= 1'b0;
            write_q        <= 1'b0;
            rdata_q        <= 16'h0000;
            phy_md_addr_q  <= 5'h00;
            phy_reg_addr_q <= 5'h00;
            phy_wr_data_q  <= 16'h0000;
            rd_stb_q       <= 1'b0;
            wr_stb_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            grant_q        <= grant_d;
            rr_q           <= rr_d;
            to_cnt_q       <= to_cnt_d;
            err_q          <= err_d;
            write_q        <= write_d;
            rdata_q        <= rdata_d;
            phy_md_addr_q  <= phy_md_addr_d;
            phy_reg_addr_q <= phy_reg_addr_d;
            phy_wr_data_q  <= phy_wr_data_d;
            rd_stb_q       <= rd_stb_d;
            wr_stb_q       <= wr_stb_d;
        end
    end

    always_comb begin
        done = '0;
        err  = '0;
        if (state_q == StDone && 32'(grant_q) < NUM_REQ) begin
            done[grant_q] = 1'b1;
            err[grant_q]  = err_q;
        end
    end

    assign rdata        = rdata_q;
    assign phy_md_addr  = phy_md_addr_q;
    assign phy_reg_addr = phy_reg_addr_q;
    assign phy_wr_data  = phy_wr_data_q;
    assign phy_reg_wr   = wr_stb_q;
    assign phy_reg_rd   = rd_stb_q;

`ifdef MDIO_AUTOPOLL_EN
    localparam int unsigned PollW = $clog2(POLL_INTERVAL);

    logic [PollW-1:0] poll_cnt_q, poll_cnt_d;
    logic             poll_pend_q, poll_pend_d;
    logic             poll_link_q, poll_link_d;
    logic             poll_valid_q, poll_valid_d;
    logic             poll_taken;
    logic             poll_done;

    assign poll_taken = (state_q == StIssue) && (32'(grant_q) == NUM_REQ);
    assign poll_done  = (state_q == StDone) && (32'(grant_q) == NUM_REQ);

    always_comb begin
        poll_cnt_d   = poll_cnt_q + 1'b1;
        poll_pend_d  = poll_pend_q;
        poll_link_d  = poll_link_q;
        poll_valid_d = poll_valid_q;
        if (poll_taken) begin
            poll_pend_d = 1'b0;
        end
        // A single pending bit: intervals elapsing while pending do not stack.
        if (poll_cnt_q == PollW'(POLL_INTERVAL - 1)) begin
            poll_cnt_d  = '0;
            poll_pend_d = 1'b1;
        end
        if (poll_done && !err_q) begin
            poll_link_d  = rdata_q[MDIO_BMSR_LINK_BIT];
            poll_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            poll_cnt_q   <= '0;
            poll_pend_q  <= 1'b0;
            poll_link_q  <= 1'b0;
            poll_valid_q <= 1'b0;
        end else begin
            poll_cnt_q   <= poll_cnt_d;
            poll_pend_q  <= poll_pend_d;
            poll_link_q  <= poll_link_d;
            poll_valid_q <= poll_valid_d;
        end
    end

    assign poll_req     = poll_pend_q;
    assign poll_link_up = poll_link_q;
    assign poll_valid   = poll_valid_q;
`else
    assign poll_req     = 1'b0;
    assign poll_link_up = 1'b0;
    assign poll_valid   = 1'b0;
`endif

endmodule

// File: tb/tb_mgmt_mdio_arbiter.sv
// Directed bench for mgmt_mdio_arbiter with a simple transceiver model (MDIO_AUTOPOLL_EN aware).
module tb_mgmt_mdio_arbiter;

`ifdef MDIO_AUTOPOLL_EN
    localparam int unsigned TbPollInterval = 200;
    localparam logic [15:0] ModelData      = 16'h0004;
`else
    localparam int unsigned TbPollInterval = 25000000;
    localparam logic [15:0] ModelData      = 16'hBEEF;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req_valid = '0;
    logic [1:0]  req_write = '0;
    logic [9:0]  req_md_addr = '0;
    logic [9:0]  req_reg_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [1:0]  done;
    logic [1:0]  err;
    logic [15:0] rdata;
    logic [4:0]  phy_md_addr;
    logic [4:0]  phy_reg_addr;
    logic [15:0] phy_wr_data;
    logic        phy_reg_wr;
    logic        phy_reg_rd;
    logic        mgmt_busy = 1'b0;
    logic        poll_link_up;
    logic        poll_valid;

    mgmt_mdio_arbiter #(
        .NUM_REQ       (2),
        .BUSY_TIMEOUT  (16),
        .POLL_INTERVAL (TbPollInterval),
        .POLL_PHY_ADDR (5'h0A)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_write    (req_write),
        .req_md_addr  (req_md_addr),
        .req_reg_addr (req_reg_addr),
        .req_wdata    (req_wdata),
        .done         (done),
        .err          (err),
        .rdata        (rdata),
        .phy_md_addr  (phy_md_addr),
        .phy_reg_addr (phy_reg_addr),
        .phy_wr_data  (phy_wr_data),
        .phy_reg_wr   (phy_reg_wr),
        .phy_reg_rd   (phy_reg_rd),
        .phy_rd_data  (ModelData),
        .mgmt_busy    (mgmt_busy),
        .poll_link_up (poll_link_up),
        .poll_valid   (poll_valid)
    );

    always #5 clk = ~clk;

    // Transceiver model: busy rises 2 cycles after a strobe and stays high 64 cycles.
    logic model_en = 1'b1;
    int   model_dly = 0;
    int   model_hold = 0;
    always @(posedge clk) begin
        if ((phy_reg_rd || phy_reg_wr) && model_en) begin
            model_dly <= 2;
        end else if (model_dly > 1) begin
            model_dly <= model_dly - 1;
        end else if (model_dly == 1) begin
            model_dly  <= 0;
            mgmt_busy  <= 1'b1;
            model_hold <= 63;
        end else if (mgmt_busy) begin
            if (model_hold == 0) mgmt_busy <= 1'b0;
            else model_hold <= model_hold - 1;
        end
    end

    int rd_pulses = 0;
    int wr_pulses = 0;
    int done_cnt = 0;
    int overlap_viol = 0;
    int poll_strobes = 0;
    bit outstanding = 1'b0;
    logic [4:0] last_md = '0;
    logic [4:0] last_reg = '0;
    always @(negedge clk) begin
        if (phy_reg_rd) rd_pulses++;
        if (phy_reg_wr) wr_pulses++;
        if (done != 2'b00) done_cnt++;
        if (phy_reg_rd || phy_reg_wr) begin
            if (outstanding) overlap_viol++;
            outstanding = 1'b1;
            last_md  = phy_md_addr;
            last_reg = phy_reg_addr;
            if (phy_md_addr == 5'h0A) poll_strobes++;
        end
        if (done != 2'b00 || !rst_n) outstanding = 1'b0;
    end

    int passed = 0;
    int total = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic wait_done(input string tag, output logic [1:0] d, output logic [1:0] e);
        bit seen = 1'b0;
        d = '0;
        e = '0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (done != 2'b00) begin
                d = done;
                e = err;
                seen = 1'b1;
                break;
            end
        end
        if (!seen) check({tag, "_timeout"}, 32'(seen), 32'd1);
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    logic [1:0] d;
    logic [1:0] e;
    int n;
    int snap;

    initial begin
        cycles(3);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_rdata", 32'(rdata), 32'd0);
        check("rst_phy", {phy_md_addr, phy_reg_addr, phy_wr_data, phy_reg_rd, phy_reg_wr}, 32'd0);
        check("rst_poll", {poll_valid, poll_link_up}, 32'd0);
        rst_n = 1'b1;

`ifndef MDIO_AUTOPOLL_EN
        // 1) read by requester 0
        req_md_addr[4:0] = 5'd1;
        req_reg_addr[4:0] = 5'd2;
        req_valid = 2'b01;
        wait_done("t1", d, e);
        req_valid = 2'b00;
        check("t1_done", 32'(d), 32'h1);
        check("t1_err", 32'(e), 32'h0);
        check("t1_rdata", 32'(rdata), 32'hBEEF);
        check("t1_md", 32'(phy_md_addr), 32'd1);
        check("t1_reg", 32'(phy_reg_addr), 32'd2);
        check("t1_rd_pulses", 32'(rd_pulses), 32'd1);

        // 2) both held: rr pointer sits at 1 after the grant to 0
        req_md_addr[9:5] = 5'd3;
        req_reg_addr[9:5] = 5'd4;
        req_valid = 2'b11;
        wait_done("t2a", d, e);
        check("t2_grant0", 32'(d), 32'h2);
        wait_done("t2b", d, e);
        check("t2_grant1", 32'(d), 32'h1);
        wait_done("t2c", d, e);
        check("t2_grant2", 32'(d), 32'h2);
        wait_done("t2d", d, e);
        check("t2_grant3", 32'(d), 32'h1);
        req_valid = 2'b00;
        check("t2_overlap", 32'(overlap_viol), 32'd0);

        // 3) write by requester 1
        cycles(2);
        req_write = 2'b10;
        req_wdata[31:16] = 16'h1234;
        req_valid = 2'b10;
        wait_done("t3", d, e);
        req_valid = 2'b00;
        req_write = 2'b00;
        check("t3_done", 32'(d), 32'h2);
        check("t3_err", 32'(e), 32'h0);
        check("t3_wdata", 32'(phy_wr_data), 32'h1234);
        check("t3_wr_pulses", 32'(wr_pulses), 32'd1);
        check("t3_rdata_kept", 32'(rdata), 32'hBEEF);

        // 4) busy never rises: timeout 16 cycles after WAIT_RISE entry
        cycles(2);
        model_en = 1'b0;
        req_valid = 2'b01;
        n = 0;
        while (!phy_reg_rd && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("t4_strobe_seen", 32'(phy_reg_rd), 32'd1);
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            n++;
            if (done != 2'b00) break;
        end
        req_valid = 2'b00;
        check("t4_latency", 32'(n), 32'd17);
        check("t4_done", 32'(done), 32'h1);
        check("t4_err", 32'(err), 32'h1);
        model_en = 1'b1;

        // 5) reset during WAIT_FALL
        cycles(2);
        req_valid = 2'b10;
        n = 0;
        while (!mgmt_busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("t5_busy_seen", 32'(mgmt_busy), 32'd1);
        cycles(5);
        snap = done_cnt;
        rst_n = 1'b0;
        req_valid = 2'b00;
        cycles(3);
        rst_n = 1'b1;
        check("t5_rdata_reset", 32'(rdata), 32'd0);
        cycles(80);
        check("t5_no_done", 32'(done_cnt - snap), 32'd0);
        req_md_addr[4:0] = 5'd7;
        req_reg_addr[4:0] = 5'd9;
        req_valid = 2'b01;
        wait_done("t5", d, e);
        req_valid = 2'b00;
        check("t5_done", 32'(d), 32'h1);
        check("t5_rdata", 32'(rdata), 32'hBEEF);
        check("t5_md", 32'(phy_md_addr), 32'd7);
        check("t5_reg", 32'(phy_reg_addr), 32'd9);

        // 6) autopoll compiled out
        check("t6_poll_off", {poll_valid, poll_link_up}, 32'd0);
        check("end_overlap", 32'(overlap_viol), 32'd0);
`else
        // 6) first autopoll after 200 cycles
        n = 0;
        while (!poll_valid && n < 600) begin
            @(negedge clk);
            n++;
        end
        check("t6_valid", 32'(poll_valid), 32'd1);
        check("t6_link", 32'(poll_link_up), 32'd1);
        check("t6_md", 32'(last_md), 32'h0A);
        check("t6_reg", 32'(last_reg), 32'h01);
        check("t6_poll_count", 32'(poll_strobes), 32'd1);
        // requester 0 held continuously: pending poll must wait for a gap
        req_md_addr[4:0] = 5'd1;
        req_reg_addr[4:0] = 5'd2;
        req_valid = 2'b01;
        snap = poll_strobes;
        for (int k = 0; k < 5; k++) begin
            wait_done("t6_req0", d, e);
            check("t6_req0_done", 32'(d), 32'h1);
        end
        req_valid = 2'b00;
        check("t6_poll_held_off", 32'(poll_strobes - snap), 32'd0);
        n = 0;
        while (poll_strobes == snap && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("t6_poll_after_gap", 32'(poll_strobes - snap), 32'd1);
        check("t6_overlap", 32'(overlap_viol), 32'd0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
